jtag_tap_ctrl: RTL
==================

JTAG_TAP_CTRL -- requirements
Module: jtag_tap_ctrl

Interface
REQ-001 Parameter IR_WIDTH, default 4: instruction register width; SHALL be at least 2.
REQ-002 Parameter NUM_UDR, default 5: number of user data-register chains; SHALL satisfy 1 <= NUM_UDR < min(IDCODE_OP, USERCODE_OP).
REQ-003 Parameter IDCODE_OP, default 4'h7: opcode selecting the 32-bit IDCODE register.
REQ-004 Parameter USERCODE_OP, default 4'h8: opcode selecting the 32-bit USERCODE register.
REQ-005 Parameter IDCODE_VAL, default 32'h1000_0001 (bit0=1 mandatory): value captured by IDCODE.
REQ-006 Parameter USERCODE_VAL, default 32'h0000_0000: value captured by USERCODE.
REQ-007 Ports: one clock, TCK; reset TRST is asynchronous and active-high.
REQ-008 TCK  in  1  sole clock; rising edge for state, IR and DR; falling edge for TDO.
REQ-009 TRST  in  1  asynchronous active-high reset.
REQ-010 TMS  in  1  mode select, sampled on rising TCK.
REQ-011 TDI  in  1  serial data in, sampled on rising TCK.
REQ-012 TDO  out  1  serial data out, changes on falling TCK only.
REQ-013 TDO_EN  out  1  high while TDO carries valid Shift-IR/Shift-DR data.
REQ-014 udr_tdo  in  NUM_UDR  serial out bit of each user chain.
REQ-015 udr_sel  out  NUM_UDR  one-hot user chain select; all zero if no user chain is selected.
REQ-016 capture_dr / shift_dr / update_dr  out  1 each  DR strobes, qualified by udr_sel in user logic.
REQ-017 run_idle  out  1  high in Run-Test/Idle (BIST start qualifier).
REQ-018 tap_state  out  4  current TAP state code; ir  out  IR_WIDTH  current instruction.

Function
REQ-019 The FSM SHALL implement all 16 IEEE 1149.1 states, with codes TLR F, RTI C, SelDR 7, CapDR 6, ShDR 2, Ex1DR 1, PauseDR 3, Ex2DR 0, UpdDR 5, SelIR 4, CapIR E, ShIR A, Ex1IR 9, PauseIR B, Ex2IR 8, UpdIR D.
REQ-020 Transitions SHALL follow the standard TMS graph; from any state, five consecutive TMS=1 edges SHALL reach TLR.
REQ-021 In CapIR the IR shift register SHALL load {zeros, 2'b01}.
REQ-022 In ShIR it SHALL shift right with TDI entering the MSB, so the LSB is shifted first.
REQ-023 On the rising edge leaving UpdIR, ir SHALL take the shift-register value.
REQ-024 ir SHALL hold its value in every other state.
REQ-025 In TLR, ir SHALL be forced to IDCODE_OP.
REQ-026 Decode: ir = k with 1 <= k <= NUM_UDR selects user chain k-1 (udr_sel bit k-1).
REQ-027 Decode: IDCODE_OP selects IDCODE and USERCODE_OP selects USERCODE.
REQ-028 Decode: every other value, including all-ones and 0, selects BYPASS.
REQ-029 udr_sel SHALL be registered, updating in the same cycle as ir.
REQ-030 BYPASS: 1-bit register, captures 0 in CapDR, shifts TDI in ShDR.
REQ-031 IDCODE/USERCODE: 32-bit register, loads its _VAL in CapDR, shifts right LSB first in ShDR.
REQ-032 capture_dr, shift_dr, update_dr and run_idle SHALL be decoded combinationally from the state register: high exactly while in CapDR, ShDR, UpdDR and RTI respectively.
REQ-033 User chains SHALL act on the rising TCK edge while their strobe is high.
REQ-034 On each falling TCK edge: in ShIR, TDO = IR shift bit0; in ShDR, TDO = bit0 of the selected register or udr_tdo[sel]; TDO_EN = 1 in both states.
REQ-035 In all other states, TDO = 0 and TDO_EN = 0.
REQ-036 Pause states SHALL hold all shift registers unchanged; Ex2 -> Shift SHALL resume without recapture.

Reset
REQ-037 TRST=1 SHALL immediately force: state TLR, ir = IDCODE_OP, udr_sel = 0, all shift registers 0, TDO = 0, TDO_EN = 0.
REQ-038 TRST asserted mid-shift SHALL abort the scan with no update_dr pulse.
REQ-039 After TRST deasserts, the first TMS=0 rising edge SHALL move the FSM to RTI.

Structure
REQ-040 Package jtag_pkg SHALL hold the 16 state codes, the default opcodes (IDCODE 7, USERCODE 8, BYPASS F) and the IR capture pattern 2'b01.
REQ-041 The TAP state machine SHALL be the sub-module jtag_tap_fsm (inputs TCK, TRST, TMS; output tap_state); decode, registers and TDO mux stay in the top module.

Verification
REQ-042 TRST pulse, then scan DR 32 bits -> tap_state F, then C; TDO emits 32'h1000_0001 LSB first; TDO_EN high for exactly 32 cycles.
REQ-043 Enter ShDR, then TMS=1 for 5 edges -> tap_state F and ir = 7, with no update_dr strobe.
REQ-044 IR scan of 4'h4 -> first two TDO bits 1 then 0; after UpdIR udr_sel = 5'b01000; a 10-bit DR scan gives capture_dr 1 cycle, shift_dr 10 cycles, update_dr 1 cycle.
REQ-045 IR = 4'hF, shift 8'b10100101 LSB first -> TDO is 0 first, then the input delayed by one TCK.
REQ-046 IR = 4'h6 (undefined) -> BYPASS behaviour and udr_sel = 0.
REQ-047 Scan with PauseDR 4 cycles between bits 5 and 6 of a 16-bit USERCODE scan -> the serial stream is identical to an unpaused scan.

Source files
------------

// File: rtl/jtag_pkg.sv
// Shared JTAG TAP definitions: the 16 TAP state codes, the default opcodes,
// the IR capture pattern and the TMS transition function.
package jtag_pkg;

   typedef enum logic [3:0] {
      TLR      = 4'hF,
      RTI      = 4'hC,
      SEL_DR   = 4'h7,
      CAP_DR   = 4'h6,
      SH_DR    = 4'h2,
      EX1_DR   = 4'h1,
      PAUSE_DR = 4'h3,
      EX2_DR   = 4'h0,
      UPD_DR   = 4'h5,
      SEL_IR   = 4'h4,
      CAP_IR   = 4'hE,
      SH_IR    = 4'hA,
      EX1_IR   = 4'h9,
      PAUSE_IR = 4'hB,
      EX2_IR   = 4'h8,
      UPD_IR   = 4'hD
   } tap_state_e;

   localparam logic [3:0] IDCODE_OP_DEF   = 4'h7;
   localparam logic [3:0] USERCODE_OP_DEF = 4'h8;
   localparam logic [3:0] BYPASS_OP_DEF   = 4'hF;

   // Fixed pattern loaded into the IR shifter in Capture-IR.
   localparam logic [1:0] IR_CAPTURE = 2'b01;

   // TMS transition graph. Kept here so the top can look one edge ahead
   // (the IR is forced to IDCODE on the same edge the FSM enters TLR).
   function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
      tap_state_e n;
      n = TLR;
      case (s)
         TLR:      n = tms ? TLR      : RTI;
         RTI:      n = tms ? SEL_DR   : RTI;
         SEL_DR:   n = tms ? SEL_IR   : CAP_DR;
         CAP_DR:   n = tms ? EX1_DR   : SH_DR;
         SH_DR:    n = tms ? EX1_DR   : SH_DR;
         EX1_DR:   n = tms ? UPD_DR   : PAUSE_DR;
         PAUSE_DR: n = tms ? EX2_DR   : PAUSE_DR;
         EX2_DR:   n = tms ? UPD_DR   : SH_DR;
         UPD_DR:   n = tms ? SEL_DR   : RTI;
         SEL_IR:   n = tms ? TLR      : CAP_IR;
         CAP_IR:   n = tms ? EX1_IR   : SH_IR;
         SH_IR:    n = tms ? EX1_IR   : SH_IR;
         EX1_IR:   n = tms ? UPD_IR   : PAUSE_IR;
         PAUSE_IR: n = tms ? EX2_IR   : PAUSE_IR;
         EX2_IR:   n = tms ? UPD_IR   : SH_IR;
         UPD_IR:   n = tms ? SEL_DR   : RTI;
         default:  n = TLR;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 TAP controller state machine, clocked on rising TCK.
module jtag_tap_fsm
   import jtag_pkg::*;
(
   input  logic       TCK,
   input  logic       TRST,
   input  logic       TMS,
   output logic [3:0] tap_state
);

   tap_state_e state_q, state_d;

   // Next state from the TMS graph.
   always_comb begin
      state_d = state_q;
      state_d = tap_next(state_q, TMS);
   end

   // State register; TRST drops straight into Test-Logic-Reset.
   always_ff @(posedge TCK or posedge TRST) begin
      if (TRST) state_q <= TLR;
      else      state_q <= state_d;
   end

   assign tap_state = state_q;

endmodule

// File: rtl/jtag_tap_ctrl.sv
// JTAG TAP controller top: IR, instruction decode, BYPASS and ID/USERCODE
// data registers, user-chain selects/strobes and the falling-edge TDO mux.
// NUM_UDR must stay below both fixed opcodes so the decodes never overlap.
module jtag_tap_ctrl
   import jtag_pkg::*;
#(
   parameter int unsigned          IR_WIDTH     = 4,
   parameter int unsigned          NUM_UDR      = 5,
   parameter logic [IR_WIDTH-1:0]  IDCODE_OP    = IR_WIDTH'(IDCODE_OP_DEF),
   parameter logic [IR_WIDTH-1:0]  USERCODE_OP  = IR_WIDTH'(USERCODE_OP_DEF),
   parameter logic [31:0]          IDCODE_VAL   = 32'h1000_0001,
   parameter logic [31:0]          USERCODE_VAL = 32'h0000_0000
) (
   input  logic                TCK,
   input  logic                TRST,
   input  logic                TMS,
   input  logic                TDI,
   output logic                TDO,
   output logic                TDO_EN,
   input  logic [NUM_UDR-1:0]  udr_tdo,
   output logic [NUM_UDR-1:0]  udr_sel,
   output logic                capture_dr,
   output logic                shift_dr,
   output logic                update_dr,
   output logic                run_idle,
   output logic [3:0]          tap_state,
   output logic [IR_WIDTH-1:0] ir
);

   logic [3:0]          tap_state_w;
   tap_state_e          state, state_nx;

   logic [IR_WIDTH-1:0] ir_shift_q, ir_shift_d;
   logic [IR_WIDTH-1:0] ir_q, ir_d;
   logic [NUM_UDR-1:0]  udr_sel_q, udr_sel_d;
   logic                bypass_q, bypass_d;
   logic [31:0]         data_q, data_d;
   logic                tdo_q, tdo_d;
   logic                tdo_en_q, tdo_en_d;

   logic                sel_idcode, sel_usercode, sel_user, sel_bypass, sel_data32;

   jtag_tap_fsm u_fsm (
      .TCK       (TCK),
      .TRST      (TRST),
      .TMS       (TMS),
      .tap_state (tap_state_w)
   );

   assign state    = tap_state_e'(tap_state_w);
   assign state_nx = tap_next(state, TMS);

   // Decode of the active instruction.
   assign sel_idcode   = (ir_q == IDCODE_OP);
   assign sel_usercode = (ir_q == USERCODE_OP);
   assign sel_user     = |udr_sel_q;
   assign sel_data32   = sel_idcode | sel_usercode;
   assign sel_bypass   = ~(sel_data32 | sel_user);

   // Instruction update: IDCODE whenever the next state is TLR, otherwise
   // load the shifter on the edge leaving Update-IR.
   always_comb begin
      ir_d = ir_q;
      if (state_nx == TLR)
         ir_d = IDCODE_OP;
      else if (state == UPD_IR)
         ir_d = ir_shift_q;
   end

   // User chain selects follow the next instruction so they change with ir.
   generate
      for (genvar gi = 0; gi < NUM_UDR; gi++) begin : g_udr_sel
         assign udr_sel_d[gi] = (ir_d == IR_WIDTH'(gi + 1));
      end
   endgenerate

   // IR shifter: capture the fixed pattern, shift LSB first with TDI at MSB.
   always_comb begin
      ir_shift_d = ir_shift_q;
      case (state)
         CAP_IR:  ir_shift_d = IR_WIDTH'(IR_CAPTURE);
         SH_IR:   ir_shift_d = {TDI, ir_shift_q[IR_WIDTH-1:1]};
         default: ir_shift_d = ir_shift_q;
      endcase
   end

   // Data registers only move when their instruction is active; pause and
   // exit states fall through to hold.
   always_comb begin
      bypass_d = bypass_q;
      data_d   = data_q;
      case (state)
         CAP_DR: begin
            if (sel_bypass) bypass_d = 1'b0;
            if (sel_data32) data_d   = sel_idcode ? IDCODE_VAL : USERCODE_VAL;
         end
         SH_DR: begin
            if (sel_bypass) bypass_d = TDI;
            if (sel_data32) data_d   = {TDI, data_q[31:1]};
         end
         default: begin
            bypass_d = bypass_q;
            data_d   = data_q;
         end
      endcase
   end

   // Serial output selection for the shift states.
   always_comb begin
      tdo_d    = 1'b0;
      tdo_en_d = 1'b0;
      if (state == SH_IR) begin
         tdo_d    = ir_shift_q[0];
         tdo_en_d = 1'b1;
      end else if (state == SH_DR) begin
         tdo_en_d = 1'b1;
         if (sel_data32)    tdo_d = data_q[0];
         else if (sel_user) tdo_d = |(udr_tdo & udr_sel_q);
         else               tdo_d = bypass_q;
      end
   end

   // Rising-edge registers: IR, selects and shift registers.
   always_ff @(posedge TCK or posedge TRST) begin
      if (TRST) begin
         ir_shift_q <= '0;
         ir_q       <= IDCODE_OP;
         udr_sel_q  <= '0;
         bypass_q   <= 1'b0;
         data_q     <= '0;
      end else begin
         ir_shift_q <= ir_shift_d;
         ir_q       <= ir_d;
         udr_sel_q  <= udr_sel_d;
         bypass_q   <= bypass_d;
         data_q     <= data_d;
      end
   end

   // TDO and its enable launch on falling TCK.
   always_ff @(negedge TCK or posedge TRST) begin
      if (TRST) begin
         tdo_q    <= 1'b0;
         tdo_en_q <= 1'b0;
      end else begin
         tdo_q    <= tdo_d;
         tdo_en_q <= tdo_en_d;
      end
   end

   assign TDO        = tdo_q;
   assign TDO_EN     = tdo_en_q;
   assign udr_sel    = udr_sel_q;
   assign ir         = ir_q;
   assign tap_state  = tap_state_w;
   assign capture_dr = (state == CAP_DR);
   assign shift_dr   = (state == SH_DR);
   assign update_dr  = (state == UPD_DR);
   assign run_idle   = (state == RTI);

endmodule
